conv33_weight_loader: RTL and testbench
=======================================

Name: conv33_weight_loader

Overview:
Responder side of the conv33 start/done stage handshake for the weight-load stage. It accepts the level-held weight_start from the conv33 stage controller and reads CH×9 kernel words from a synchronous weight memory. It packs those words into a flat register bank for the compute array and returns a single-cycle weight_done. It sits between the stage controller and the weight BRAM/ROM.

Parameters:
DATA_W, 8, width of one weight word
CH, 1, number of 3×3 kernels loaded per request (N = 9*CH words)
ADDR_W, 10, weight memory address width
BASE_ADDR, 0, memory address of word 0
RD_LAT, 1, memory read latency in cycles (1..4)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
weight_start  in  1  level request from the stage controller; held high until weight_done is seen
weight_done  out  1  registered one-cycle pulse when all N words are captured
mem_en  out  1  memory read enable
mem_addr  out  ADDR_W  memory read address
mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after mem_en
weights  out  N*DATA_W  packed kernels; word k occupies [k*DATA_W +: DATA_W], with k = ch*9 + row*3 + col
weights_valid  out  1  high while weights holds a complete, current set

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE; weight_done, mem_en, weights_valid = 0; mem_addr = BASE_ADDR; weights = 0; counters = 0.
- States: IDLE, READ, DRAIN, DONE, WAIT_LOW.
- IDLE:
  - When weight_start is sampled high: go to READ, clear weights_valid, reset the issue and capture counters.
  - The weights contents are not cleared.
- READ:
  - mem_en is registered high for exactly N consecutive cycles.
  - mem_addr = BASE_ADDR + k for k = 0..N-1, one address per cycle.
  - After the last issue, go to DRAIN.
- Capture:
  - An RD_LAT-deep valid shift register tracks issued reads.
  - Each returning word is written to slot capture_cnt; capture_cnt then increments.
  - Capture runs in both READ and DRAIN.
- DRAIN:
  - When capture N-1 is written, go to DONE.
  - On that same edge, weight_done <= 1 and weights_valid <= 1.
- DONE:
  - Lasts one cycle; weight_done returns to 0 on exit.
  - Go to WAIT_LOW.
- WAIT_LOW:
  - Return to IDLE only when weight_start is sampled low.
  - This prevents a re-trigger because the controller drops start one cycle after done.
- Latency: with weight_start first sampled at edge E0, weight_done is high in the cycle after edge E0+N+RD_LAT.
  - CH=1, RD_LAT=1: done in the 10th cycle after E0.
- Abort: if weight_start is sampled low in READ or DRAIN:
  - go to IDLE, mem_en = 0;
  - ignore in-flight returns;
  - no weight_done; weights_valid stays 0.
- weight_start high in IDLE on the same edge as reset release: start is sampled on the first clock edge after rst_n goes high.
- Reset mid-operation: all state returns to reset values immediately; no done is produced.
- Address arithmetic: BASE_ADDR + k truncates modulo 2^ADDR_W; wrap-around is permitted and not flagged.
- weights is held stable outside capture; it changes only on capture edges.

Optional Feature:
Macro: CONV33_WEIGHT_CHECKSUM_EN.
- When defined: extra output port checksum [DATA_W+$clog2(N+1)-1:0].
  - Cleared when a load starts.
  - Accumulates the unsigned sum of every captured word.
  - Final value is valid while weights_valid = 1.
- When undefined: no port and no accumulator logic.

Decomposition:
- Shared package conv33_pkg:
  - state encoding localparams;
  - KERNEL_WORDS = 9;
  - the word-index formula helper.
- One natural sub-module, conv33_rd_pipe: the RD_LAT-deep valid shift register, which delivers a capture strobe. It is reusable by the input loader.

Test Plan:
- CH=1, RD_LAT=1, memory[k]=k+1; hold weight_start:
  - mem_en high 9 cycles with addresses 0..8;
  - weight_done is a 1-cycle pulse 10 cycles after start;
  - weights word k = k+1; weights_valid = 1.
- Hold weight_start high 3 cycles after done: no second mem_en burst; drop start, re-raise it → a new load begins and weights_valid drops to 0 during the load.
- CH=2, RD_LAT=3, BASE_ADDR=1020, ADDR_W=10:
  - addresses wrap 1020..1023, 0..13;
  - done after 18+3 cycles;
  - word 17 = mem[13].
- Drop weight_start at issue 4 → mem_en low next cycle; no weight_done; weights_valid = 0; a late mem_rdata return does not change weights.
- Assert rst_n=0 mid-READ → immediate reset values; after release, a fresh start completes normally.
- With CONV33_WEIGHT_CHECKSUM_EN defined, CH=1, all words = 8'hFF → checksum = 2295 at done.

Source files
------------

// File: rtl/conv33_pkg.sv
// Shared definitions for the conv33 loaders: stage FSM encoding, kernel size
// and the packed-word index helper.
package conv33_pkg;

  localparam int unsigned KERNEL_WORDS = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE,
    ST_WAIT_LOW
  } state_e;

  // Slot of kernel element (row, col) of channel ch in the packed bank.
  function automatic int unsigned word_index(input int unsigned ch,
                                             input int unsigned row,
                                             input int unsigned col);
    return ch * KERNEL_WORDS + row * 3 + col;
  endfunction

endpackage

// File: rtl/conv33_rd_pipe.sv
// Tracks issued memory reads through an LAT-deep valid shift register and
// raises strobe in the cycle the matching read data is present.
module conv33_rd_pipe #(
  parameter int unsigned LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic issue,
  output logic strobe
);

  logic [LAT-1:0] valid_q, valid_d;

  always_comb begin
    valid_d    = valid_q << 1;
    valid_d[0] = issue;
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  assign strobe = valid_q[LAT-1];

endmodule

// File: rtl/conv33_weight_loader.sv
// Weight-load responder for the conv33 start/done handshake: reads CH*9 words
// into a flat bank. Define CONV33_WEIGHT_CHECKSUM_EN for the checksum output.
module conv33_weight_loader
  import conv33_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CH        = 1,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              weight_start,
  output logic                              weight_done,
  output logic                              mem_en,
  output logic [ADDR_W-1:0]                 mem_addr,
  input  logic [DATA_W-1:0]                 mem_rdata,
  output logic [CH*KERNEL_WORDS*DATA_W-1:0] weights,
  output logic                              weights_valid
`ifdef CONV33_WEIGHT_CHECKSUM_EN
  ,
  output logic [DATA_W+$clog2(CH*KERNEL_WORDS+1)-1:0] checksum
`endif
);

  localparam int unsigned N     = CH * KERNEL_WORDS;
  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0]  LAST = CNT_W'(N - 1);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_e              state_q, state_d;
  logic                done_q, done_d;
  logic                en_q, en_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]    cap_cnt_q, cap_cnt_d;
  logic [N*DATA_W-1:0] weights_q, weights_d;
  logic                flush;
  logic                strobe;
`ifdef CONV33_WEIGHT_CHECKSUM_EN
  localparam int unsigned CK_W = DATA_W + $clog2(N + 1);
  logic [CK_W-1:0]     cksum_q, cksum_d;
`endif

  conv33_rd_pipe #(.LAT(RD_LAT)) u_rd_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .issue  (en_q),
    .strobe (strobe)
  );

  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    en_d        = en_q;
    valid_d     = valid_q;
    addr_d      = addr_q;
    issue_cnt_d = issue_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    weights_d   = weights_q;
    flush       = 1'b0;
`ifdef CONV33_WEIGHT_CHECKSUM_EN
    cksum_d     = cksum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (weight_start) begin
          state_d     = ST_READ;
          en_d        = 1'b1;
          addr_d      = BASE;
          issue_cnt_d = '0;
          cap_cnt_d   = '0;
          valid_d     = 1'b0;
`ifdef CONV33_WEIGHT_CHECKSUM_EN
          cksum_d     = '0;
`endif
        end
      end
      ST_READ, ST_DRAIN: begin
        if (!weight_start) begin
          // Abort: drop the request and discard reads still in flight.
          state_d = ST_IDLE;
          en_d    = 1'b0;
          flush   = 1'b1;
        end else begin
          if (state_q == ST_READ) begin
            if (issue_cnt_q == LAST) begin
              en_d    = 1'b0;
              state_d = ST_DRAIN;
            end else begin
              addr_d      = addr_q + 1'b1;
              issue_cnt_d = issue_cnt_q + 1'b1;
            end
          end
          if (strobe) begin
            weights_d[int'(cap_cnt_q)*DATA_W +: DATA_W] = mem_rdata;
            cap_cnt_d = cap_cnt_q + 1'b1;
`ifdef CONV33_WEIGHT_CHECKSUM_EN
            cksum_d   = cksum_q + CK_W'(mem_rdata);
`endif
            if (cap_cnt_q == LAST) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              valid_d = 1'b1;
            end
          end
        end
      end
      ST_DONE:     state_d = ST_WAIT_LOW;
      ST_WAIT_LOW: if (!weight_start) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      done_q      <= 1'b0;
      en_q        <= 1'b0;
      valid_q     <= 1'b0;
      addr_q      <= BASE;
      issue_cnt_q <= '0;
      cap_cnt_q   <= '0;
      weights_q   <= '0;
`ifdef CONV33_WEIGHT_CHECKSUM_EN
      cksum_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      en_q        <= en_d;
      valid_q     <= valid_d;
      addr_q      <= addr_d;
      issue_cnt_q <= issue_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      weights_q   <= weights_d;
`ifdef CONV33_WEIGHT_CHECKSUM_EN
      cksum_q     <= cksum_d;
`endif
    end
  end

  assign weight_done   = done_q;
  assign mem_en        = en_q;
  assign mem_addr      = addr_q;
  assign weights       = weights_q;
  assign weights_valid = valid_q;
`ifdef CONV33_WEIGHT_CHECKSUM_EN
  assign checksum      = cksum_q;
`endif

endmodule

// File: tb/tb_conv33_weight_loader.sv
// Directed bench for conv33_weight_loader: CH=1/RD_LAT=1 and CH=2/RD_LAT=3
// wrapping instances, plus a checksum instance when CONV33_WEIGHT_CHECKSUM_EN is set.
module tb_conv33_weight_loader;
  import conv33_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic start_a, start_b;

  always #5 clk = ~clk;

  logic        done_a, en_a, valid_a;
  logic [9:0]  addr_a;
  logic [7:0]  rdata_a;
  logic [71:0] weights_a;
  logic [7:0]  mem_a [0:15];

  logic         done_b, en_b, valid_b;
  logic [9:0]   addr_b;
  logic [7:0]   rdata_b, b_s0, b_s1;
  logic [143:0] weights_b;

`ifdef CONV33_WEIGHT_CHECKSUM_EN
  logic [11:0] cks_a, cks_c;
  logic [12:0] cks_b;
  logic        done_c, en_c, valid_c;
  logic [9:0]  addr_c;
  logic [71:0] weights_c;
  logic [7:0]  rdata_c;
  assign rdata_c = 8'hFF;
`endif

  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] fb(input int a);
    return 8'(a) ^ 8'h5A;
  endfunction

  always @(posedge clk) if (en_a) rdata_a <= mem_a[addr_a[3:0]];

  always @(posedge clk) begin
    b_s0    <= en_b ? fb(int'(addr_b)) : 8'h00;
    b_s1    <= b_s0;
    rdata_b <= b_s1;
  end

  conv33_weight_loader #(
    .DATA_W(8), .CH(1), .ADDR_W(10), .BASE_ADDR(0), .RD_LAT(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .weight_start(start_a), .weight_done(done_a),
    .mem_en(en_a), .mem_addr(addr_a), .mem_rdata(rdata_a),
    .weights(weights_a), .weights_valid(valid_a)
`ifdef CONV33_WEIGHT_CHECKSUM_EN
    , .checksum(cks_a)
`endif
  );

  conv33_weight_loader #(
    .DATA_W(8), .CH(2), .ADDR_W(10), .BASE_ADDR(1020), .RD_LAT(3)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .weight_start(start_b), .weight_done(done_b),
    .mem_en(en_b), .mem_addr(addr_b), .mem_rdata(rdata_b),
    .weights(weights_b), .weights_valid(valid_b)
`ifdef CONV33_WEIGHT_CHECKSUM_EN
    , .checksum(cks_b)
`endif
  );

`ifdef CONV33_WEIGHT_CHECKSUM_EN
  conv33_weight_loader #(
    .DATA_W(8), .CH(1), .ADDR_W(10), .BASE_ADDR(0), .RD_LAT(1)
  ) dut_c (
    .clk(clk), .rst_n(rst_n), .weight_start(start_a), .weight_done(done_c),
    .mem_en(en_c), .mem_addr(addr_c), .mem_rdata(rdata_c),
    .weights(weights_c), .weights_valid(valid_c), .checksum(cks_c)
  );
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Waits (bounded) for done_a; a timeout counts as a failed comparison.
  task automatic wait_done_a(input int budget);
    int seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_a) begin seen = 1; break; end
    end
    chk("A done within budget", 32'(seen), 32'd1);
  endtask

  typedef struct {
    bit         en;
    bit         chk_addr;
    logic [9:0] addr;
    bit         done;
    bit         valid;
  } vec_t;

  vec_t tbl [14];

  initial begin
    // Cycle c is the cycle after edge E0+c, E0 being the first edge that samples start.
    tbl[0]  = '{1, 1, 10'd0, 0, 0};
    tbl[1]  = '{1, 1, 10'd1, 0, 0};
    tbl[2]  = '{1, 1, 10'd2, 0, 0};
    tbl[3]  = '{1, 1, 10'd3, 0, 0};
    tbl[4]  = '{1, 1, 10'd4, 0, 0};
    tbl[5]  = '{1, 1, 10'd5, 0, 0};
    tbl[6]  = '{1, 1, 10'd6, 0, 0};
    tbl[7]  = '{1, 1, 10'd7, 0, 0};
    tbl[8]  = '{1, 1, 10'd8, 0, 0};
    tbl[9]  = '{0, 0, 10'd0, 0, 0};
    tbl[10] = '{0, 0, 10'd0, 1, 1};
    tbl[11] = '{0, 0, 10'd0, 0, 1};
    tbl[12] = '{0, 0, 10'd0, 0, 1};
    tbl[13] = '{0, 0, 10'd0, 0, 1};

    for (int k = 0; k < 16; k++) mem_a[k] = 8'(k + 1);
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    repeat (2) @(negedge clk);

    chk("reset A done", 32'(done_a), 0);
    chk("reset A mem_en", 32'(en_a), 0);
    chk("reset A addr", 32'(addr_a), 0);
    chk("reset A valid", 32'(valid_a), 0);
    chk("reset A weights lo", weights_a[31:0], 0);
    chk("reset B addr", 32'(addr_b), 32'd1020);
    chk("reset B mem_en", 32'(en_b), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full load, then start held for three cycles past done.
    start_a = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      chk($sformatf("A c%0d mem_en", c), 32'(en_a), 32'(tbl[c].en));
      if (tbl[c].chk_addr) chk($sformatf("A c%0d addr", c), 32'(addr_a), 32'(tbl[c].addr));
      chk($sformatf("A c%0d done", c), 32'(done_a), 32'(tbl[c].done));
      chk($sformatf("A c%0d valid", c), 32'(valid_a), 32'(tbl[c].valid));
      if (c == 10) begin
        for (int k = 0; k < 9; k++)
          chk($sformatf("A word%0d", k), 32'(weights_a[k*8 +: 8]), 32'(k + 1));
`ifdef CONV33_WEIGHT_CHECKSUM_EN
        chk("C done", 32'(done_c), 1);
        chk("C checksum", 32'(cks_c), 32'd2295);
        chk("A checksum", 32'(cks_a), 32'd45);
`endif
      end
    end

    start_a = 1'b0;
    repeat (2) @(negedge clk);
    chk("A idle mem_en", 32'(en_a), 0);
    chk("A idle valid kept", 32'(valid_a), 1);

    // Re-raise: valid drops as the new load begins.
    start_a = 1'b1;
    @(negedge clk);
    chk("A reload valid low", 32'(valid_a), 0);
    chk("A reload mem_en", 32'(en_a), 1);
    wait_done_a(30);
    @(negedge clk);
    chk("A reload valid", 32'(valid_a), 1);
    chk("A reload word8", 32'(weights_a[71:64]), 32'd9);
    start_a = 1'b0;
    repeat (2) @(negedge clk);

    // Abort at issue 4 with new memory contents.
    for (int k = 0; k < 16; k++) mem_a[k] = 8'hA0 + 8'(k);
    start_a = 1'b1;
    for (int c = 0; c < 5; c++) @(negedge clk);
    chk("abort issue4 mem_en", 32'(en_a), 1);
    chk("abort issue4 addr", 32'(addr_a), 32'd4);
    start_a = 1'b0;
    @(negedge clk);
    chk("abort mem_en low", 32'(en_a), 0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("abort no done", 32'(done_a), 0);
      chk("abort valid low", 32'(valid_a), 0);
    end
    for (int k = 0; k < 9; k++)
      chk($sformatf("abort word%0d", k), 32'(weights_a[k*8 +: 8]),
          (k < 3) ? 32'(8'hA0 + 8'(k)) : 32'(k + 1));

    // Reset in the middle of READ.
    start_a = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst mem_en", 32'(en_a), 0);
    chk("midrst addr", 32'(addr_a), 0);
    chk("midrst valid", 32'(valid_a), 0);
    chk("midrst done", 32'(done_a), 0);
    chk("midrst weights lo", weights_a[31:0], 0);
    chk("midrst weights hi", 32'(weights_a[71:32]), 0);
    start_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_a = 1'b1;
    wait_done_a(30);
    chk("post-rst valid", 32'(valid_a), 1);
    for (int k = 0; k < 9; k++)
      chk($sformatf("post-rst word%0d", k), 32'(weights_a[k*8 +: 8]), 32'(8'hA0 + 8'(k)));
    start_a = 1'b0;
    repeat (2) @(negedge clk);

    // CH=2, RD_LAT=3, base 1020: wrapping addresses.
    begin
      int nissue = 0;
      int done_cyc = -1;
      start_b = 1'b1;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (en_b) begin
          chk($sformatf("B issue%0d addr", nissue), 32'(addr_b), 32'((1020 + nissue) % 1024));
          nissue++;
        end
        if (done_b) begin done_cyc = c; break; end
      end
      chk("B issue count", 32'(nissue), 32'd18);
      chk("B done cycle", 32'(done_cyc), 32'd21);
      chk("B valid", 32'(valid_b), 1);
      for (int k = 0; k < 18; k++)
        chk($sformatf("B word%0d", k), 32'(weights_b[k*8 +: 8]), 32'(fb((1020 + k) % 1024)));
      chk("B word17 = mem[13]", 32'(weights_b[word_index(1, 2, 2)*8 +: 8]), 32'(fb(13)));
`ifdef CONV33_WEIGHT_CHECKSUM_EN
      begin
        int s = 0;
        for (int k = 0; k < 18; k++) s += int'(fb((1020 + k) % 1024));
        chk("B checksum", 32'(cks_b), 32'(s));
      end
`endif
      @(negedge clk);
      chk("B done pulse ends", 32'(done_b), 0);
      start_b = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
